// File: rtl/rotate_checker_if.sv
// Rotator output bus: sample-enable plus the observed rotator data word.
// The rotator (or a bench) drives it as master; rotate_checker consumes it as slave.
interface rotate_checker_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic [WIDTH-1:0] din;

  modport master (output en, output din);
  modport slave  (input  en, input  din);
endinterface

// File: rtl/rotate_checker.sv
// Receive-side monitor that locks onto a left or right rotation sequence on the
// rotator bus. Optional ROTCHK_ERRCNT_EN adds a saturating 8-bit error counter.
module rotate_checker #(
  parameter int WIDTH = 4,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rotate_checker_if.slave  bus,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic [REV_W-1:0] rev_cnt
`ifdef ROTCHK_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [WIDTH-1:0]   expected;
`ifdef ROTCHK_ERRCNT_EN
  logic [7:0]         err_cnt_q, err_cnt_d;
`endif

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  // A pattern invariant under rotation by a proper divisor of WIDTH cannot
  // reveal a direction, so it is never allowed to establish lock.
  function automatic logic is_degenerate(input logic [WIDTH-1:0] x);
    logic             deg;
    logic [WIDTH-1:0] r;
    deg = 1'b0;
    for (int k = 1; k < WIDTH; k++) begin
      if (WIDTH % k == 0) begin
        r = (x << k) | (x >> (WIDTH - k));
        if (r == x) deg = 1'b1;
      end
    end
    return deg;
  endfunction

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    step_d      = step_q;
    dir_d       = dir_q;
    err_d       = 1'b0;
    rev_cnt_d   = rev_cnt_q;
    expected    = dir_q ? rotl(prev_q) : rotr(prev_q);
`ifdef ROTCHK_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    if (bus.en) begin
      case (state_q)
        SEARCH: begin
          prev_d      = bus.din;
          have_prev_d = 1'b1;
          if (have_prev_q && !is_degenerate(prev_q)) begin
            if (bus.din == rotl(prev_q)) begin
              state_d   = LOCKED;
              dir_d     = 1'b1;
              step_d    = STEP_W'(1);
              rev_cnt_d = '0;
            end else if (bus.din == rotr(prev_q)) begin
              state_d   = LOCKED;
              dir_d     = 1'b0;
              step_d    = STEP_W'(1);
              rev_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          prev_d = bus.din;
          if (bus.din == expected) begin
            if (step_q == LAST_STEP) begin
              step_d = '0;
              if (rev_cnt_q != '1) rev_cnt_d = rev_cnt_q + REV_W'(1);
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end else begin
            // The erroring sample seeds the next search; rev_cnt is kept.
            err_d       = 1'b1;
            state_d     = SEARCH;
            have_prev_d = 1'b1;
            step_d      = '0;
`ifdef ROTCHK_ERRCNT_EN
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      step_q      <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      rev_cnt_q   <= '0;
`ifdef ROTCHK_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      rev_cnt_q   <= rev_cnt_d;
`ifdef ROTCHK_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign locked  = (state_q == LOCKED);
  assign dir     = dir_q;
  assign err     = err_q;
  assign rev_cnt = rev_cnt_q;
`ifdef ROTCHK_ERRCNT_EN
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rotate_checker.sv
// Scoreboard bench for rotate_checker: directed rotation sequences push expected
// outputs into a queue; monitors pop and compare after each edge or reset pulse.
module tb_rotate_checker;

  localparam int W  = 4;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          dir;
  logic          err;
  logic [RW-1:0] rev_cnt;
`ifdef ROTCHK_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  always #10 clk = ~clk;

  rotate_checker_if #(.WIDTH(W)) bus ();

  rotate_checker #(.WIDTH(W), .REV_W(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .locked  (locked),
    .dir     (dir),
    .err     (err),
    .rev_cnt (rev_cnt)
`ifdef ROTCHK_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  typedef struct packed {
    logic          lk;
    logic          dr;
    logic          er;
    logic [RW-1:0] rv;
    logic [7:0]    ec;
    logic [15:0]   id;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         vec_id   = 0;
  logic [7:0] ecnt     = 8'd0;
  event       check_now;

  function automatic logic [W-1:0] rotl4(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction

  task automatic check_output();
    exp_t       x;
    logic       ok;
    logic [7:0] act_ec;
    x  = sb_q.pop_front();
    ok = (locked === x.lk) && (dir === x.dr) && (err === x.er) && (rev_cnt === x.rv);
`ifdef ROTCHK_ERRCNT_EN
    act_ec = err_cnt;
    ok = ok && (err_cnt === x.ec);
`else
    act_ec = x.ec;
`endif
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL vec %0d locked/dir/err/rev_cnt/err_cnt: got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
               x.id, locked, dir, err, rev_cnt, act_ec, x.lk, x.dr, x.er, x.rv, x.ec);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) check_output();
  end

  always @(check_now) begin
    if (sb_q.size() > 0) check_output();
  end

  task automatic push_exp(input logic lk, input logic dr, input logic er, input logic [RW-1:0] rv);
    exp_t x;
    vec_id++;
    x.lk = lk;
    x.dr = dr;
    x.er = er;
    x.rv = rv;
    x.ec = ecnt;
    x.id = vec_id[15:0];
    sb_q.push_back(x);
  endtask

  task automatic apply_stimulus(input logic e, input logic [W-1:0] d, input logic lk,
                                input logic dr, input logic er, input logic [RW-1:0] rv);
    @(negedge clk);
    bus.en  = e;
    bus.din = d;
    push_exp(lk, dr, er, rv);
  endtask

  // Async reset pulse placed between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    @(posedge clk);
    #4 rst_n = 1'b0;
    #2;
    ecnt = 8'd0;
    push_exp(1'b0, 1'b0, 1'b0, '0);
    ->check_now;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] d;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.din = '0;
    #3;
    push_exp(1'b0, 1'b0, 1'b0, '0);
    ->check_now;
    #5 rst_n = 1'b1;

    $display("[TB] continuous left rotation");
    d = 4'b0001;
    for (int i = 1; i <= 41; i++) begin
      apply_stimulus(1'b1, d, i >= 2, i >= 2, 1'b0, (i >= 2) ? RW'((i - 1) / 4) : '0);
      d = rotl4(d);
    end

    $display("[TB] glitch during left lock");
    reset_pulse();
    apply_stimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 16'd1);
    apply_stimulus(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 16'd1);
    ecnt++;
    apply_stimulus(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 16'd1);
    apply_stimulus(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 16'd0);

    $display("[TB] right rotation of 0111 and reversal");
    reset_pulse();
    apply_stimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 16'd1);
    ecnt++;
    apply_stimulus(1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 16'd1);
    apply_stimulus(1'b1, 4'b1101, 1'b1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 16'd0);

    $display("[TB] degenerate pattern");
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, (i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0, 1'b0, 1'b0, 16'd0);
    end

    $display("[TB] enable gaps with garbage data");
    reset_pulse();
    d = 4'b0001;
    for (int i = 1; i <= 41; i++) begin
      apply_stimulus(1'b1, d, i >= 2, i >= 2, 1'b0, (i >= 2) ? RW'((i - 1) / 4) : '0);
      apply_stimulus(1'b0, 4'(i * 5 + 3), i >= 2, i >= 2, 1'b0, (i >= 2) ? RW'((i - 1) / 4) : '0);
      d = rotl4(d);
    end

    $display("[TB] reset mid-operation");
    reset_pulse();
    d = 4'b0001;
    for (int i = 1; i <= 13; i++) begin
      apply_stimulus(1'b1, d, i >= 2, i >= 2, 1'b0, (i >= 2) ? RW'((i - 1) / 4) : '0);
      d = rotl4(d);
    end
    reset_pulse();
    apply_stimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 16'd0);

    @(posedge clk);
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_checker.md
# rotate_checker

- Receive-side monitor for the 4-bit rotator output bus.
- Samples the bus every enabled clock and locks onto a valid rotation sequence in either direction.
- Reports lock, direction, completed revolutions and sequence errors.
- Sits on the rotator's `out` bus, in the design or the bench, as the consumer end of that interface.

## Interface
- `WIDTH`, default 4: bus width; one revolution is `WIDTH` consecutive rotation steps.
- `REV_W`, default 16: width of the revolution counter.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: sample-enable; `din` is evaluated only on edges where `en`=1.
- `din` input WIDTH: observed rotator output.
- `locked` output 1: the checker is tracking a valid rotation.
- `dir` output 1: direction while locked; 1 = left (`{d[W-2:0],d[W-1]}`), 0 = right.
- `err` output 1: one-cycle pulse on a mismatch while locked.
- `rev_cnt` output REV_W: completed revolutions since the last lock; saturates at all-ones.
- `err_cnt` output 8: present only with `ROTCHK_ERRCNT_EN`.

## Operation
- Internal state:
  - `prev`: last enabled sample.
  - `have_prev`: `prev` holds a valid sample.
  - `step`, range 0..WIDTH-1: transitions since the last revolution boundary.
  - FSM states SEARCH and LOCKED.
- Degenerate pattern: any value equal to its own rotation by a proper divisor of WIDTH. For WIDTH=4 these are 0000, 1111, 0101 and 1010. A degenerate pattern can never establish lock.
- SEARCH, on an enabled edge:
  - `prev`←`din` and `have_prev`←1.
  - If `have_prev` is set and `prev` is non-degenerate:
    - `din`==rotl(`prev`) → LOCKED, `dir`←1, `step`←1, `rev_cnt`←0.
    - Otherwise `din`==rotr(`prev`) → LOCKED, `dir`←0, `step`←1, `rev_cnt`←0.
  - Any other value: remain in SEARCH.
- LOCKED, on an enabled edge, compute expected = `dir` ? rotl(`prev`) : rotr(`prev`).
  - Match: `prev`←`din`.
    - If `step`==WIDTH-1: `step`←0 and `rev_cnt`←`rev_cnt`+1, saturating.
    - Otherwise `step`←`step`+1.
  - Mismatch:
    - `err`←1 for one cycle; go to SEARCH.
    - `prev`←`din`, `have_prev`←1, `step`←0.
    - `rev_cnt` holds its value until the next lock.
- `en`=0: all state holds and `err`←0.
- Reset values:
  - `locked`=0, `dir`=0, `err`=0, `rev_cnt`=0, `err_cnt`=0.
  - `prev`=0, `have_prev`=0, `step`=0, state SEARCH.
- `locked` is 1 exactly when the state is LOCKED.

## Timing
- All outputs are registered; there is no combinational path from `din` or `en` to any output.
- Lock latency: with valid samples at enabled edges k and k+1, `locked`=1 immediately after edge k+1.
- `err` asserts after the edge that captures the mismatching sample, for exactly one cycle. At that same edge `locked` falls.
- Re-lock needs at least one more enabled edge after the error, since the erroring sample seeds `prev`.
- First revolution: from a lock with `step`=1, `rev_cnt` becomes 1 after WIDTH-1 further matching edges. For WIDTH=4 that is 5 samples total from first sample to `rev_cnt`=1.
- A reversal of direction while LOCKED is a mismatch. It gives `err`, then SEARCH, then re-lock in the new direction on the next matching edge.
- `rst_n` falling mid-operation forces all reset values immediately, independent of `clk`. The first edge after release is treated as a SEARCH sample with `have_prev`=0.
- `rev_cnt` at all-ones stays at all-ones; `step` continues to wrap.

## Configuration
- `ROTCHK_ERRCNT_EN` defined:
  - `err_cnt[7:0]` port exists.
  - It increments on every `err` pulse and saturates at 255.
  - It is cleared only by reset.
- `ROTCHK_ERRCNT_EN` undefined: the `err_cnt` port and its register are absent; all other behaviour is identical.

## Test plan
- Continuous left rotation: reset, `en`=1, `din` 0001,0010,0100,1000,0001,… → `locked`=1, `dir`=1 after the 2nd sample; `rev_cnt`=1 after the 5th sample; `rev_cnt`=10 after the 41st sample; `err` never asserts.
- Right rotation of 0111: 0111,1011,1101,1110 → `locked`=1, `dir`=0 after 1011; `rev_cnt`=1 after the sample following 1110.
- Glitch: lock on 0001 left, then inject 0011 in place of 0100 →
  - `err` is a single-cycle pulse, `locked`=0, `rev_cnt` holds.
  - Next sample 0110 → re-lock, `rev_cnt`=0.
  - With the macro, `err_cnt`=1.
- Degenerate input: 0101,1010,0101,… for 20 edges → `locked` stays 0 and `err` stays 0.
- Enable gaps: left rotation from 0001 with `en`=0 on alternate cycles while `din` holds garbage → identical lock and count results to the first scenario, counted in enabled edges only.
- Reset mid-operation: while LOCKED with `rev_cnt`=3, pulse `rst_n`=0 between edges → all outputs 0 immediately; after release the checker needs 2 samples to re-lock.
